dut_run_sequencer: RTL and testbench

Host-side sequencer for the matrix-vector DUT's run/busy handshake. It writes the two-word problem header into the input SRAM and the weight memory, raises `dut_run`, and tracks `dut_busy` through its rise and fall with a watchdog. It then reads the DUT's result words back out of the output SRAM and streams them to the host on a valid/ready port. It is the reader for the DUT's `dut_sram_write_*` writer and the initiator for its `dut_run`/`dut_busy` responder.

---
 rtl/dut_run_sequencer.sv | 209 ++++++++++++++++++++
 tb/tb_dut_run_sequencer.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/dut_run_sequencer.sv
// Host-side run sequencer: writes the two-word problem header, drives the DUT
// run/busy handshake under a watchdog, then streams result words to the host.
module dut_run_sequencer #(
  parameter int ADDR_W         = 12,
  parameter int DATA_W         = 16,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic              clk,
  input  logic              reset_b,
  input  logic              start,
  input  logic [15:0]       cfg_num_inputs,
  input  logic [15:0]       cfg_input_width,
  input  logic [15:0]       cfg_dim,
  input  logic [15:0]       cfg_weight_width,
  input  logic [ADDR_W-1:0] cfg_num_outputs,
  output logic              seq_busy,
  output logic              done,
  output logic              timeout,
  output logic [ADDR_W-1:0] hdr_sram_write_address,
  output logic [DATA_W-1:0] hdr_sram_write_data,
  output logic              hdr_sram_write_enable,
  output logic [ADDR_W-1:0] hdr_wmem_write_address,
  output logic [DATA_W-1:0] hdr_wmem_write_data,
  output logic              hdr_wmem_write_enable,
  output logic              dut_run,
  input  logic              dut_busy,
  output logic [ADDR_W-1:0] res_sram_read_address,
  input  logic [DATA_W-1:0] res_sram_read_data,
  output logic              res_valid,
  output logic [DATA_W-1:0] res_data,
  output logic [ADDR_W-1:0] res_index,
  input  logic              res_ready
);

  // state   | meaning
  // S_IDLE  | waiting for start
  // S_HDR0  | header word 0 written to both memories
  // S_HDR1  | header word 1 written to both memories
  // S_RUNHI | dut_run high, waiting for dut_busy to rise
  // S_RUNLO | dut_run low, waiting for dut_busy to fall
  // S_RDADR | output SRAM address presented
  // S_RDDAT | output SRAM data captured into the result register
  // S_OUT   | result offered to the host until accepted
  // S_DONE  | one-cycle completion pulse
  typedef enum logic [3:0] {
    S_IDLE, S_HDR0, S_HDR1, S_RUNHI, S_RUNLO, S_RDADR, S_RDDAT, S_OUT, S_DONE
  } state_t;

  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

  state_t            state_q, state_d;
  logic [15:0]       num_inputs_q, num_inputs_d;
  logic [15:0]       input_width_q, input_width_d;
  logic [15:0]       dim_q, dim_d;
  logic [15:0]       weight_width_q, weight_width_d;
  logic [ADDR_W-1:0] num_outputs_q, num_outputs_d;
  logic [ADDR_W-1:0] index_q, index_d;
  logic [WD_W-1:0]   wd_q, wd_d;
  logic              timeout_q, timeout_d;
  logic              res_valid_q, res_valid_d;
  logic [DATA_W-1:0] res_data_q, res_data_d;
  logic [ADDR_W-1:0] res_index_q, res_index_d;
  logic [ADDR_W-1:0] index_inc;

  assign index_inc = index_q + 1'b1;

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      state_q        <= S_IDLE;
      num_inputs_q   <= '0;
      input_width_q  <= '0;
      dim_q          <= '0;
      weight_width_q <= '0;
      num_outputs_q  <= '0;
      index_q        <= '0;
      wd_q           <= '0;
      timeout_q      <= 1'b0;
      res_valid_q    <= 1'b0;
      res_data_q     <= '0;
      res_index_q    <= '0;
    end else begin
      state_q        <= state_d;
      num_inputs_q   <= num_inputs_d;
      input_width_q  <= input_width_d;
      dim_q          <= dim_d;
      weight_width_q <= weight_width_d;
      num_outputs_q  <= num_outputs_d;
      index_q        <= index_d;
      wd_q           <= wd_d;
      timeout_q      <= timeout_d;
      res_valid_q    <= res_valid_d;
      res_data_q     <= res_data_d;
      res_index_q    <= res_index_d;
    end
  end

  always_comb begin
    state_d                = state_q;
    num_inputs_d           = num_inputs_q;
    input_width_d          = input_width_q;
    dim_d                  = dim_q;
    weight_width_d         = weight_width_q;
    num_outputs_d          = num_outputs_q;
    index_d                = index_q;
    wd_d                   = wd_q;
    timeout_d              = timeout_q;
    res_valid_d            = res_valid_q;
    res_data_d             = res_data_q;
    res_index_d            = res_index_q;
    done                   = 1'b0;
    dut_run                = 1'b0;
    hdr_sram_write_address = '0;
    hdr_sram_write_data    = '0;
    hdr_sram_write_enable  = 1'b0;
    hdr_wmem_write_address = '0;
    hdr_wmem_write_data    = '0;
    hdr_wmem_write_enable  = 1'b0;
    res_sram_read_address  = '0;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          num_inputs_d   = cfg_num_inputs;
          input_width_d  = cfg_input_width;
          dim_d          = cfg_dim;
          weight_width_d = cfg_weight_width;
          num_outputs_d  = cfg_num_outputs;
          timeout_d      = 1'b0;
          state_d        = S_HDR0;
        end
      end
      S_HDR0: begin
        hdr_sram_write_enable = 1'b1;
        hdr_sram_write_data   = DATA_W'(num_inputs_q);
        hdr_wmem_write_enable = 1'b1;
        hdr_wmem_write_data   = DATA_W'(dim_q);
        state_d               = S_HDR1;
      end
      S_HDR1: begin
        hdr_sram_write_enable  = 1'b1;
        hdr_sram_write_address = ADDR_W'(1);
        hdr_sram_write_data    = DATA_W'(input_width_q);
        hdr_wmem_write_enable  = 1'b1;
        hdr_wmem_write_address = ADDR_W'(1);
        hdr_wmem_write_data    = DATA_W'(weight_width_q);
        wd_d                   = '0;
        state_d                = S_RUNHI;
      end
      S_RUNHI: begin
        dut_run = 1'b1;
        if (dut_busy) begin
          wd_d    = '0;
          state_d = S_RUNLO;
        end else if (wd_q == WD_LAST) begin
          timeout_d = 1'b1;
          state_d   = S_DONE;
        end else begin
          wd_d = wd_q + 1'b1;
        end
      end
      S_RUNLO: begin
        // A busy fall in the expiry cycle still counts as a normal finish.
        if (!dut_busy) begin
          if (num_outputs_q == '0) begin
            state_d = S_DONE;
          end else begin
            index_d = '0;
            state_d = S_RDADR;
          end
        end else if (wd_q == WD_LAST) begin
          timeout_d = 1'b1;
          state_d   = S_DONE;
        end else begin
          wd_d = wd_q + 1'b1;
        end
      end
      S_RDADR: begin
        res_sram_read_address = index_q;
        state_d               = S_RDDAT;
      end
      S_RDDAT: begin
        res_data_d  = res_sram_read_data;
        res_index_d = index_q;
        res_valid_d = 1'b1;
        state_d     = S_OUT;
      end
      S_OUT: begin
        if (res_ready) begin
          res_valid_d = 1'b0;
          index_d     = index_inc;
          state_d     = (index_inc == num_outputs_q) ? S_DONE : S_RDADR;
        end
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign seq_busy  = (state_q != S_IDLE);
  assign timeout   = timeout_q;
  assign res_valid = res_valid_q;
  assign res_data  = res_data_q;
  assign res_index = res_index_q;

endmodule

// File: tb/tb_dut_run_sequencer.sv
// Directed bench for dut_run_sequencer: a busy-responder model and output SRAM
// model drive the main instance; a second instance with a short watchdog never sees busy.
module tb_dut_run_sequencer;
  localparam int ADDR_W     = 12;
  localparam int DATA_W     = 16;
  localparam int BUSY_DELAY = 3;
  localparam int BUSY_LEN   = 20;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              reset_b, start, start_wd, res_ready, dut_busy;
  logic [15:0]       cfg_num_inputs, cfg_input_width, cfg_dim, cfg_weight_width;
  logic [ADDR_W-1:0] cfg_num_outputs;
  logic [DATA_W-1:0] sram_q;
  logic [DATA_W-1:0] out_mem [0:7];

  logic              seq_busy, done, timeout, we_s, we_w, dut_run, res_valid;
  logic [ADDR_W-1:0] addr_s, addr_w, rd_addr, res_index;
  logic [DATA_W-1:0] data_s, data_w, res_data;

  logic              seq_busy_x, done_x, timeout_x, we_s_x, we_w_x, dut_run_x, res_valid_x;
  logic [ADDR_W-1:0] addr_s_x, addr_w_x, rd_addr_x, res_index_x;
  logic [DATA_W-1:0] data_s_x, data_w_x, res_data_x;

  dut_run_sequencer #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_dut (
    .clk(clk), .reset_b(reset_b), .start(start),
    .cfg_num_inputs(cfg_num_inputs), .cfg_input_width(cfg_input_width),
    .cfg_dim(cfg_dim), .cfg_weight_width(cfg_weight_width), .cfg_num_outputs(cfg_num_outputs),
    .seq_busy(seq_busy), .done(done), .timeout(timeout),
    .hdr_sram_write_address(addr_s), .hdr_sram_write_data(data_s), .hdr_sram_write_enable(we_s),
    .hdr_wmem_write_address(addr_w), .hdr_wmem_write_data(data_w), .hdr_wmem_write_enable(we_w),
    .dut_run(dut_run), .dut_busy(dut_busy),
    .res_sram_read_address(rd_addr), .res_sram_read_data(sram_q),
    .res_valid(res_valid), .res_data(res_data), .res_index(res_index), .res_ready(res_ready)
  );

  dut_run_sequencer #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT_CYCLES(8)) u_dut_wd (
    .clk(clk), .reset_b(reset_b), .start(start_wd),
    .cfg_num_inputs(cfg_num_inputs), .cfg_input_width(cfg_input_width),
    .cfg_dim(cfg_dim), .cfg_weight_width(cfg_weight_width), .cfg_num_outputs(cfg_num_outputs),
    .seq_busy(seq_busy_x), .done(done_x), .timeout(timeout_x),
    .hdr_sram_write_address(addr_s_x), .hdr_sram_write_data(data_s_x), .hdr_sram_write_enable(we_s_x),
    .hdr_wmem_write_address(addr_w_x), .hdr_wmem_write_data(data_w_x), .hdr_wmem_write_enable(we_w_x),
    .dut_run(dut_run_x), .dut_busy(1'b0),
    .res_sram_read_address(rd_addr_x), .res_sram_read_data(16'h0000),
    .res_valid(res_valid_x), .res_data(res_data_x), .res_index(res_index_x), .res_ready(1'b1)
  );

  always @(posedge clk) sram_q <= out_mem[rd_addr[2:0]];

  // Responder: busy rises BUSY_DELAY cycles after run is first seen, stays BUSY_LEN cycles.
  int   mdl_cnt;
  logic mdl_wait;
  always @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      dut_busy <= 1'b0; mdl_wait <= 1'b0; mdl_cnt <= 0;
    end else if (mdl_wait) begin
      if (mdl_cnt == BUSY_DELAY - 1) begin
        mdl_wait <= 1'b0; dut_busy <= 1'b1; mdl_cnt <= 1;
      end else mdl_cnt <= mdl_cnt + 1;
    end else if (dut_busy) begin
      if (mdl_cnt == BUSY_LEN) begin
        dut_busy <= 1'b0; mdl_cnt <= 0;
      end else mdl_cnt <= mdl_cnt + 1;
    end else if (dut_run) begin
      mdl_wait <= 1'b1; mdl_cnt <= 1;
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_main(input logic [15:0] ni, input logic [15:0] iw, input logic [15:0] dm,
                          input logic [15:0] ww, input int n_out, input int stall_idx,
                          input int stall_len, input bit poke_start);
    int run_rise, run_fall, busy_rise, busy_fall, hs_cnt, last_hs, valid_rises, stall, done_cyc;
    bit prev_valid, prev_busy, prev_run, got_done;
    logic [DATA_W-1:0] hold_data;
    logic [ADDR_W-1:0] hold_idx;
    cfg_num_inputs = ni; cfg_input_width = iw; cfg_dim = dm; cfg_weight_width = ww;
    cfg_num_outputs = ADDR_W'(n_out);
    res_ready = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    cfg_num_inputs = ~ni; cfg_input_width = ~iw; cfg_dim = ~dm; cfg_weight_width = ~ww;
    cfg_num_outputs = ADDR_W'(n_out + 2);
    check_eq("hdr0_sram", {we_s, addr_s, data_s}, {1'b1, 12'd0, ni});
    check_eq("hdr0_wmem", {we_w, addr_w, data_w}, {1'b1, 12'd0, dm});
    tick();
    check_eq("hdr1_sram", {we_s, addr_s, data_s}, {1'b1, 12'd1, iw});
    check_eq("hdr1_wmem", {we_w, addr_w, data_w}, {1'b1, 12'd1, ww});
    tick();
    check_eq("run_hi_entry", {dut_run, we_s, we_w}, 3'b100);
    run_rise = cyc; run_fall = -1; busy_rise = -1; busy_fall = -1;
    hs_cnt = 0; last_hs = -1; valid_rises = 0; stall = 0; done_cyc = -1;
    prev_valid = 1'b0; prev_busy = 1'b0; prev_run = 1'b1; got_done = 1'b0;
    hold_data = '0; hold_idx = '0;
    for (int c = 0; c < 300 && !got_done; c++) begin
      tick();
      if (dut_busy && !prev_busy) busy_rise = cyc;
      if (!dut_busy && prev_busy) busy_fall = cyc;
      if (!dut_run && prev_run && run_fall < 0) run_fall = cyc;
      start = (poke_start && busy_rise >= 0 && cyc == busy_rise + 2);
      if (res_valid && !prev_valid) begin
        valid_rises++;
        if (valid_rises == 1) check_eq("first_valid_latency", cyc - busy_fall, 3);
      end
      if (res_valid && int'(res_index) == stall_idx && stall < stall_len) begin
        if (stall == 0) begin
          hold_data = res_data; hold_idx = res_index;
        end else begin
          check_eq("bp_data_stable", res_data, hold_data);
          check_eq("bp_index_stable", res_index, hold_idx);
        end
        stall++;
        res_ready = 1'b0;
      end else res_ready = 1'b1;
      if (res_valid && res_ready) begin
        check_eq("res_data", res_data, out_mem[hs_cnt]);
        check_eq("res_index", res_index, hs_cnt);
        if (hs_cnt > 0)
          check_eq("res_spacing", cyc - last_hs, (hs_cnt == stall_idx) ? 3 + stall_len : 3);
        hs_cnt++;
        last_hs = cyc;
      end
      if (done) begin
        got_done = 1'b1; done_cyc = cyc;
        check_eq("timeout_clear_at_done", timeout, 0);
      end
      prev_valid = res_valid; prev_busy = dut_busy; prev_run = dut_run;
    end
    start = 1'b0;
    check_eq("done_seen", got_done, 1);
    check_eq("result_count", hs_cnt, n_out);
    check_eq("sram_read_count", valid_rises, n_out);
    check_eq("run_high_cycles", run_fall - run_rise, BUSY_DELAY + 1);
    check_eq("run_fall_after_busy", run_fall - busy_rise, 1);
    if (n_out > 0) check_eq("done_after_last_hs", done_cyc - last_hs, 1);
    else check_eq("done_after_busy_fall", done_cyc - busy_fall, 1);
    tick();
    check_eq("done_one_cycle", {done, seq_busy}, 2'b00);
  endtask

  initial begin
    int wd_run, wd_rise, wd_done;
    bit wd_valid, wd_got, seen;
    out_mem[0] = 16'h0011; out_mem[1] = 16'h0022; out_mem[2] = 16'h0033; out_mem[3] = 16'h0044;
    for (int i = 4; i < 8; i++) out_mem[i] = 16'hdead;
    reset_b = 1'b0; start = 1'b0; start_wd = 1'b0; res_ready = 1'b1;
    cfg_num_inputs = '0; cfg_input_width = '0; cfg_dim = '0; cfg_weight_width = '0;
    cfg_num_outputs = '0;
    repeat (3) tick();
    check_eq("reset_ctrl", {seq_busy, done, timeout, we_s, we_w, dut_run, res_valid}, 7'b0);
    check_eq("reset_res", {res_index, res_data, rd_addr}, 40'b0);
    reset_b = 1'b1;
    tick();

    run_main(16'd16, 16'd8, 16'd16, 16'd2, 4, -1, 0, 1'b1);
    run_main(16'd32, 16'd4, 16'd64, 16'd16, 3, 1, 5, 1'b0);
    run_main(16'd5, 16'd2, 16'd7, 16'd8, 0, -1, 0, 1'b0);

    // Watchdog instance: busy never rises.
    start_wd = 1'b1;
    tick();
    start_wd = 1'b0;
    tick();
    tick();
    wd_rise = cyc; wd_run = 0; wd_valid = 1'b0; wd_got = 1'b0; wd_done = -1;
    for (int c = 0; c < 60 && !wd_got; c++) begin
      if (dut_run_x) wd_run++;
      if (res_valid_x) wd_valid = 1'b1;
      if (done_x) begin
        wd_got = 1'b1; wd_done = cyc;
        check_eq("wd_timeout_at_done", timeout_x, 1);
      end else tick();
    end
    check_eq("wd_done_seen", wd_got, 1);
    check_eq("wd_run_cycles", wd_run, 8);
    check_eq("wd_done_latency", wd_done - wd_rise, 8);
    check_eq("wd_no_results", wd_valid, 0);
    repeat (3) tick();
    check_eq("wd_timeout_sticky_idle", {timeout_x, seq_busy_x}, 2'b10);
    start_wd = 1'b1;
    tick();
    start_wd = 1'b0;
    check_eq("wd_timeout_cleared", {timeout_x, we_s_x}, 2'b01);

    // Asynchronous reset while a result waits in OUT.
    cfg_num_outputs = ADDR_W'(2);
    start = 1'b1;
    tick();
    start = 1'b0;
    res_ready = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 100 && !seen; c++) begin
      tick();
      if (res_valid) seen = 1'b1;
    end
    check_eq("out_reached", {seen, res_data}, {1'b1, 16'h0011});
    #2 reset_b = 1'b0;
    #1;
    check_eq("async_rst_ctrl", {seq_busy, done, timeout, we_s, we_w, dut_run, res_valid}, 7'b0);
    check_eq("async_rst_hdr", {addr_s, data_s, addr_w, data_w}, 56'b0);
    check_eq("async_rst_res", {res_index, res_data, rd_addr}, 40'b0);
    check_eq("async_rst_wd_ctrl",
             {seq_busy_x, done_x, timeout_x, we_s_x, we_w_x, dut_run_x, res_valid_x}, 7'b0);
    check_eq("async_rst_wd_hdr", {addr_s_x, data_s_x, addr_w_x, data_w_x}, 56'b0);
    check_eq("async_rst_wd_res", {res_index_x, res_data_x, rd_addr_x}, 40'b0);
    tick();
    reset_b = 1'b1;
    tick();
    run_main(16'd9, 16'd16, 16'd3, 16'd4, 2, -1, 0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
